// File: rtl/keypad_event_queue_if.sv
// Key event handshake bundle between the keypad event queue and its consumer.
//   evt_valid : head of event FIFO is valid (producer -> consumer)
//   evt_ready : consumer accepts the head event this cycle (consumer -> producer)
//   evt_code  : key index 0..11 (0..9 digits, 10 star, 11 sharp)
//   evt_press : 1 = press, 0 = release
interface keypad_event_queue_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_code;
    logic       evt_press;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_press,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_press,
        output evt_ready
    );
endinterface

// File: rtl/keypad_event_queue.sv
// Keypad event queue: synchronises and debounces the 12 key levels as a vector, turns debounced
// edges into {press, code} events and buffers them in a small FIFO for a valid/ready consumer.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   key_raw    : raw key levels, 1 = pressed
//   ovf_clr    : clears the sticky overflow flag
//   evt        : event handshake (master side)
//   held_keys  : debounced key vector
//   fifo_count : occupied FIFO entries
//   overflow   : sticky, a key changed again before its previous event was queued
module keypad_event_queue #(
    parameter int unsigned DEBOUNCE_CNT = 250000,
    parameter int unsigned CNT_W        = 20,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [11:0]                        key_raw,
    input  logic                               ovf_clr,
    keypad_event_queue_if.master               evt,
    output logic [11:0]                        held_keys,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               overflow
);

    localparam int unsigned CountW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);

    logic [11:0]       sync1_q, raw_sync_q, last_q, stable_q, pending_q;
    logic [11:0]       stable_d, pending_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              overflow_q, overflow_d;
    logic [4:0]        mem_q [FIFO_DEPTH];
    logic [4:0]        mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;

    logic [11:0] diff;
    logic [11:0] emit_mask;
    logic [3:0]  sel;
    logic        push, pop;

    // Debounce: one shared stability window for the whole vector.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        diff     = '0;
        if (raw_sync_q != last_q) begin
            cnt_d = '0;
        end else if (raw_sync_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CNT - 1)) begin
            stable_d = raw_sync_q;
            cnt_d    = '0;
            diff     = raw_sync_q ^ stable_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Emission: lowest pending key first, gated by the registered (pre-pop) count.
    always_comb begin
        sel = '0;
        for (int i = 11; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel = 4'(i);
            end
        end
        push      = (pending_q != '0) && (count_q < CountW'(FIFO_DEPTH));
        pop       = (count_q != '0) && evt.evt_ready;
        emit_mask = push ? (12'd1 << sel) : 12'd0;
    end

    always_comb begin
        pending_d  = (pending_q & ~emit_mask) | diff;
        overflow_d = overflow_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        // A bit emitted this cycle has already carried its old level, so only unsent ones count.
        if ((diff & pending_q & ~emit_mask) != '0) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {stable_q[sel], sel};
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CountW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CountW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            raw_sync_q <= '0;
            last_q     <= '0;
            stable_q   <= '0;
            cnt_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sync1_q    <= key_raw;
            raw_sync_q <= sync1_q;
            last_q     <= raw_sync_q;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

    assign evt.evt_valid = (count_q != '0);
    assign evt.evt_code  = mem_q[rd_ptr_q][3:0];
    assign evt.evt_press = mem_q[rd_ptr_q][4];
    assign held_keys     = stable_q;
    assign fifo_count    = count_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_keypad_event_queue.sv
module tb_keypad_event_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] key_raw;
    logic        ovf_clr;
    logic [11:0] held_keys;
    logic [2:0]  fifo_count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    keypad_event_queue_if evt_if ();

    keypad_event_queue #(
        .DEBOUNCE_CNT (8),
        .CNT_W        (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_raw    (key_raw),
        .ovf_clr    (ovf_clr),
        .evt        (evt_if),
        .held_keys  (held_keys),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] key;
        logic        ready;
        int          cycles;
        logic [11:0] exp_held;
        int          exp_count;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits up to limit edges for a head event, checks it, then advances one edge (pops if ready).
    task automatic wait_event(input int code, input int press, input int limit);
        int n = 0;
        while (!evt_if.evt_valid && n < limit) begin
            step();
            n++;
        end
        check("evt_valid", int'(evt_if.evt_valid), 1);
        check("evt_code", int'(evt_if.evt_code), code);
        check("evt_press", int'(evt_if.evt_press), press);
        step();
    endtask

    task automatic expect_quiet(input int cycles);
        int seen = 0;
        repeat (cycles) begin
            step();
            if (evt_if.evt_valid) seen++;
        end
        check("no_extra_event", seen, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int codes [6];
        codes = '{1, 2, 3, 4, 6, 8};
        vecs[0] = '{12'h002, 1'b0, 15, 12'h002, 1, 1'b0};
        vecs[1] = '{12'h006, 1'b0, 15, 12'h006, 2, 1'b0};
        vecs[2] = '{12'h00E, 1'b0, 15, 12'h00E, 3, 1'b0};
        vecs[3] = '{12'h01E, 1'b0, 15, 12'h01E, 4, 1'b0};
        vecs[4] = '{12'h05E, 1'b0, 15, 12'h05E, 4, 1'b0};
        vecs[5] = '{12'h15E, 1'b0, 15, 12'h15E, 4, 1'b0};

        rst               = 1'b1;
        key_raw           = '0;
        ovf_clr           = 1'b0;
        evt_if.evt_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(evt_if.evt_valid), 0);
        check("rst_code", int'(evt_if.evt_code), 0);
        check("rst_press", int'(evt_if.evt_press), 0);
        check("rst_held", int'(held_keys), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_ovf", int'(overflow), 0);
        rst = 1'b0;
        step();
        step();

        // Single press latency: valid exactly on edge 12
        evt_if.evt_ready = 1'b1;
        key_raw          = 12'h020;
        for (int e = 1; e <= 13; e++) begin
            step();
            check($sformatf("lat_valid_e%0d", e), int'(evt_if.evt_valid), (e == 12) ? 1 : 0);
            if (e == 10) check("lat_held_e10", int'(held_keys), 0);
            if (e == 11) check("lat_held_e11", int'(held_keys), 12'h020);
            if (e == 12) begin
                check("lat_code", int'(evt_if.evt_code), 5);
                check("lat_press", int'(evt_if.evt_press), 1);
            end
        end
        key_raw = 12'h000;
        wait_event(5, 0, 20);

        // Bounce: five toggles 3 cycles apart, ending pressed
        for (int t = 0; t < 5; t++) begin
            key_raw[3] = ~key_raw[3];
            if (t < 4) repeat (3) step();
        end
        for (int e = 1; e <= 12; e++) begin
            step();
            if (e == 11) check("bounce_valid_e11", int'(evt_if.evt_valid), 0);
            if (e == 12) begin
                check("bounce_valid_e12", int'(evt_if.evt_valid), 1);
                check("bounce_code", int'(evt_if.evt_code), 3);
                check("bounce_press", int'(evt_if.evt_press), 1);
            end
        end
        expect_quiet(20);
        key_raw = 12'h000;
        wait_event(3, 0, 20);

        // Simultaneous presses come out ascending on consecutive cycles
        key_raw = 12'h881;
        wait_event(0, 1, 20);
        wait_event(7, 1, 0);
        wait_event(11, 1, 0);
        key_raw = 12'h000;
        wait_event(0, 0, 20);
        wait_event(7, 0, 0);
        wait_event(11, 0, 0);
        step();

        // Backpressure: table of separate presses with the consumer stalled
        for (int v = 0; v < 6; v++) begin
            key_raw          = vecs[v].key;
            evt_if.evt_ready = vecs[v].ready;
            repeat (vecs[v].cycles) step();
            check($sformatf("bp_held_%0d", v), int'(held_keys), int'(vecs[v].exp_held));
            check($sformatf("bp_count_%0d", v), int'(fifo_count), vecs[v].exp_count);
            check($sformatf("bp_ovf_%0d", v), int'(overflow), int'(vecs[v].exp_ovf));
        end
        evt_if.evt_ready = 1'b1;
        for (int k = 0; k < 6; k++) wait_event(codes[k], 1, 2);
        check("bp_drained", int'(fifo_count), 0);
        key_raw = 12'h000;
        wait_event(1, 0, 20);
        for (int k = 1; k < 6; k++) wait_event(codes[k], 0, 2);
        step();

        // Overflow: key 2 pressed and released while its press is stuck behind a full FIFO
        evt_if.evt_ready = 1'b0;
        key_raw          = 12'h01B;
        repeat (20) step();
        check("ovf_full", int'(fifo_count), 4);
        check("ovf_pre", int'(overflow), 0);
        key_raw = 12'h01F;
        repeat (15) step();
        check("ovf_after_press", int'(overflow), 0);
        check("ovf_held_press", int'(held_keys), 12'h01F);
        key_raw = 12'h01B;
        repeat (15) step();
        check("ovf_set", int'(overflow), 1);
        check("ovf_count", int'(fifo_count), 4);
        check("ovf_held_rel", int'(held_keys), 12'h01B);
        evt_if.evt_ready = 1'b1;
        wait_event(0, 1, 2);
        wait_event(1, 1, 2);
        wait_event(3, 1, 2);
        wait_event(4, 1, 2);
        wait_event(2, 0, 2);
        expect_quiet(15);
        check("ovf_drained", int'(fifo_count), 0);
        check("ovf_sticky", int'(overflow), 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", int'(overflow), 0);
        key_raw = 12'h000;
        wait_event(0, 0, 20);
        wait_event(1, 0, 2);
        wait_event(3, 0, 2);
        wait_event(4, 0, 2);
        step();

        // Reset mid-stream with key 9 held
        evt_if.evt_ready = 1'b0;
        key_raw          = 12'h200;
        repeat (15) step();
        key_raw = 12'h201;
        repeat (15) step();
        check("rs_count_pre", int'(fifo_count), 2);
        #2;
        rst = 1'b1;
        #1;
        check("rs_valid", int'(evt_if.evt_valid), 0);
        check("rs_count", int'(fifo_count), 0);
        check("rs_held", int'(held_keys), 0);
        check("rs_ovf", int'(overflow), 0);
        key_raw = 12'h200;
        repeat (2) @(posedge clk);
        #1;
        rst              = 1'b0;
        evt_if.evt_ready = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (e == 11) check("rs_valid_e11", int'(evt_if.evt_valid), 0);
            if (e == 12) begin
                check("rs_valid_e12", int'(evt_if.evt_valid), 1);
                check("rs_code", int'(evt_if.evt_code), 9);
                check("rs_press", int'(evt_if.evt_press), 1);
            end
        end
        step();
        key_raw = 12'h000;
        wait_event(9, 0, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
